fc_argmax_bank: RTL and testbench
=================================

Name: fc_argmax_bank

Overview:
Parametrised successor to the fixed ten-neuron FC stage and its class decoder. It holds N_CLASSES bit-serial XNOR-popcount neurons that share one binary input stream, with one weight bit per class per beat. After a frame of N_IN beats, a sequential argmax scan produces the class index, a one-hot vector and the winning score. It sits between maxpool (input stream) and the controller (result/done).

Parameters:
N_CLASSES, 10, number of output neurons/classes (2..64)
N_IN, 144, input beats per frame (vector length)
ACC_W, $clog2(N_IN+1)+1, signed score width (derived localparam, not overridable)
IDX_W, $clog2(N_CLASSES), class index width (derived localparam)

Ports:
clk  in  1  clock, rising edge
rstn  in  1  reset: synchronous, active-high (asserted = 1)
start  in  1  one-cycle pulse; begins a frame
ivalid  in  1  input beat valid
din  in  1  input activation bit (1 = +1, 0 = -1)
weight  in  N_CLASSES  weight bit per class for this beat
in_ready  out  1  high in ACCUM; beats are accepted only when ivalid & in_ready
busy  out  1  high in ACCUM or ARGMAX
done  out  1  one-cycle pulse when results are valid
class_idx  out  IDX_W  winning class (binary)
class_onehot  out  N_CLASSES  winning class (one-hot)
max_score  out  ACC_W  signed winning score

Behaviour:
- Reset (rstn=1 at an edge): state=IDLE. Accumulators, beat counter, scan index and all outputs go to 0. done=0, busy=0, in_ready=0. Reset mid-frame aborts the frame with no done.
- FSM: IDLE -> ACCUM on start (all accumulators and the beat counter are cleared on that edge). ACCUM -> ARGMAX when the N_IN-th beat is accepted. ARGMAX -> DONE after N_CLASSES scan cycles. DONE -> IDLE after 1 cycle.
- ACCUM: on an accepted beat, acc[c] += (din XNOR weight[c]) ? +1 : -1 for every c, in parallel. The beat counter increments. ivalid gaps are allowed.
- Score range is -N_IN..+N_IN. ACC_W is sized so no overflow is possible, so no saturation is needed.
- ARGMAX: one class per cycle, index 0..N_CLASSES-1. best starts at acc[0], idx 0. Replacement requires a strictly greater score, so ties go to the lowest index.
- DONE cycle: done=1. class_idx, class_onehot and max_score are updated on the edge entering DONE and held until the next start's frame reaches DONE or until reset.
- Latency: done rises N_CLASSES+1 cycles after the edge that accepts the last beat.
- start while busy or in DONE: ignored.
- start and ivalid in the same IDLE cycle: the frame starts; that beat is not accepted because in_ready=0.
- ivalid outside ACCUM: dropped, with no effect.
- class_onehot equals 1<<class_idx whenever done has ever fired; it is 0 after reset.

Optional Feature:
FC_SCORE_OUT_EN:
- Defined: adds output port scores, N_CLASSES*ACC_W bits wide, with class c at [c*ACC_W +: ACC_W]. It carries the live accumulators and is stable from the DONE cycle until the next start.
- Undefined: the port is absent. Accumulators stay internal, with identical behaviour otherwise.

Decomposition:
- Package fc_pkg: state encoding (IDLE, ACCUM, ARGMAX, DONE), the ACC_W/IDX_W derivation functions, and the xnor-to-±1 step constant.
- One sub-module, bnn_neuron_acc: a single signed accumulator with clear, enable, din and w inputs. It is instantiated N_CLASSES times by a generate loop.
- The argmax scan and the FSM stay in the top of the block.

Test Plan:
- N_CLASSES=10, N_IN=12. din=1 for all beats, weight=10'h008 every beat -> acc3=+12, others -12; class_idx=3, class_onehot=10'h008, max_score=12, done 11 cycles after the 12th beat.
- All weights equal (weight=10'h3FF), din alternating 1/0 -> all scores 0; tie -> class_idx=0, class_onehot=10'h001, max_score=0.
- Classes 2 and 7 both scoring +10, others lower -> class_idx=2 (lowest-index tie break).
- Random ivalid gaps (50% duty) over one frame -> results match the gap-free reference model; beats arriving while in_ready=0 don't change the scores.
- start pulsed during ACCUM and ARGMAX -> ignored, beat count unaffected. rstn asserted after 5 beats -> all outputs 0, no done; a new frame afterwards gives correct results.
- With FC_SCORE_OUT_EN defined -> scores bus equals the per-class model values in the DONE cycle. Without it -> compiles with no scores port.

Source files
------------

// File: rtl/fc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fc_pkg
// Description : Shared state encoding, width helpers and step constant for the
//               fc_argmax_bank XNOR-popcount classifier stage.
// Revision    : 1.0 - initial release
// ============================================================================
package fc_pkg;

    typedef logic [1:0] fc_state_t;

    localparam fc_state_t c_st_idle   = 2'd0;
    localparam fc_state_t c_st_accum  = 2'd1;
    localparam fc_state_t c_st_argmax = 2'd2;
    localparam fc_state_t c_st_done   = 2'd3;

    // Magnitude of one XNOR product mapped to +1 / -1.
    localparam int c_step_mag = 1;

    // One sign bit on top of the magnitude range 0..n_in.
    function automatic int acc_width(input int n_in);
        return $clog2(n_in + 1) + 1;
    endfunction

    function automatic int idx_width(input int n_classes);
        return (n_classes > 1) ? $clog2(n_classes) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bnn_neuron_acc.sv
`default_nettype none
// ============================================================================
// Module      : bnn_neuron_acc
// Description : One bit-serial binary neuron: signed accumulator of XNOR(din,w)
//               mapped to +1/-1, with synchronous clear and beat enable.
// Revision    : 1.0 - initial release
// ============================================================================
module bnn_neuron_acc
    import fc_pkg::*;
#(
    parameter int ACC_W = 9
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_clr,
    input  logic                    i_en,
    input  logic                    i_din,
    input  logic                    i_w,
    output logic signed [ACC_W-1:0] o_acc
);

    localparam logic signed [ACC_W-1:0] c_step = ACC_W'(c_step_mag);

    logic signed [ACC_W-1:0] r_acc;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= (i_din ~^ i_w) ? (r_acc + c_step) : (r_acc - c_step);
        end
    end

    assign o_acc = r_acc;

endmodule
`default_nettype wire

// File: rtl/fc_argmax_bank.sv
`default_nettype none
// ============================================================================
// Module      : fc_argmax_bank
// Description : N_CLASSES bit-serial XNOR-popcount neurons on a shared input
//               stream, followed by a one-class-per-cycle argmax scan.
//               Define FC_SCORE_OUT_EN to expose the raw accumulators on 'scores'.
// Revision    : 1.0 - initial release
// ============================================================================
module fc_argmax_bank
    import fc_pkg::*;
#(
    parameter  int N_CLASSES = 10,
    parameter  int N_IN      = 144,
    localparam int ACC_W     = acc_width(N_IN),
    localparam int IDX_W     = idx_width(N_CLASSES)
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    start,
    input  logic                    ivalid,
    input  logic                    din,
    input  logic [N_CLASSES-1:0]    weight,
    output logic                    in_ready,
    output logic                    busy,
    output logic                    done,
    output logic [IDX_W-1:0]        class_idx,
    output logic [N_CLASSES-1:0]    class_onehot,
    output logic signed [ACC_W-1:0] max_score
`ifdef FC_SCORE_OUT_EN
    ,
    output logic [N_CLASSES*ACC_W-1:0] scores
`endif
);

    localparam int                   c_cnt_w     = $clog2(N_IN + 1);
    localparam logic [c_cnt_w-1:0]   c_last_beat = c_cnt_w'(N_IN - 1);
    localparam logic [c_cnt_w-1:0]   c_beat_one  = c_cnt_w'(1);
    localparam logic [IDX_W-1:0]     c_last_cls  = IDX_W'(N_CLASSES - 1);
    localparam logic [IDX_W-1:0]     c_idx_one   = IDX_W'(1);
    localparam logic [N_CLASSES-1:0] c_oh_one    = N_CLASSES'(1);

    fc_state_t               r_state;
    logic [c_cnt_w-1:0]      r_beat;
    logic [IDX_W-1:0]        r_scan;
    logic [IDX_W-1:0]        r_best_idx;
    logic signed [ACC_W-1:0] r_best;

    logic signed [ACC_W-1:0] w_acc [N_CLASSES];
    logic                    w_start;
    logic                    w_accept;
    logic signed [ACC_W-1:0] w_cand;
    logic                    w_take;
    logic signed [ACC_W-1:0] w_next_best;
    logic [IDX_W-1:0]        w_next_idx;

    assign w_start  = start  && (r_state == c_st_idle);
    assign w_accept = ivalid && (r_state == c_st_accum);

    generate
        for (genvar g = 0; g < N_CLASSES; g++) begin : g_neuron
            bnn_neuron_acc #(
                .ACC_W (ACC_W)
            ) u_acc (
                .clk   (clk),
                .rst   (rstn),
                .i_clr (w_start),
                .i_en  (w_accept),
                .i_din (din),
                .i_w   (weight[g]),
                .o_acc (w_acc[g])
            );
        end
    endgenerate

    // Scan slot 0 seeds the running best; later slots need a strictly larger
    // score, so ties resolve to the lowest class index.
    assign w_cand      = w_acc[r_scan];
    assign w_take      = (r_scan == '0) || (w_cand > r_best);
    assign w_next_best = w_take ? w_cand : r_best;
    assign w_next_idx  = w_take ? r_scan : r_best_idx;

    always_ff @(posedge clk) begin
        if (rstn) begin
            r_state      <= c_st_idle;
            r_beat       <= '0;
            r_scan       <= '0;
            r_best       <= '0;
            r_best_idx   <= '0;
            class_idx    <= '0;
            class_onehot <= '0;
            max_score    <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_state <= c_st_accum;
                        r_beat  <= '0;
                    end
                end
                c_st_accum: begin
                    if (ivalid) begin
                        r_beat <= r_beat + c_beat_one;
                        if (r_beat == c_last_beat) begin
                            r_state <= c_st_argmax;
                            r_scan  <= '0;
                        end
                    end
                end
                c_st_argmax: begin
                    r_best     <= w_next_best;
                    r_best_idx <= w_next_idx;
                    if (r_scan == c_last_cls) begin
                        r_state      <= c_st_done;
                        class_idx    <= w_next_idx;
                        class_onehot <= c_oh_one << w_next_idx;
                        max_score    <= w_next_best;
                    end else begin
                        r_scan <= r_scan + c_idx_one;
                    end
                end
                c_st_done: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign in_ready = (r_state == c_st_accum);
    assign busy     = (r_state == c_st_accum) || (r_state == c_st_argmax);
    assign done     = (r_state == c_st_done);

`ifdef FC_SCORE_OUT_EN
    generate
        for (genvar g = 0; g < N_CLASSES; g++) begin : g_score
            assign scores[g*ACC_W +: ACC_W] = w_acc[g];
        end
    endgenerate
`endif

endmodule
`default_nettype wire

// File: tb/tb_fc_argmax_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_fc_argmax_bank
// Description : Self-checking bench for fc_argmax_bank (N_CLASSES=10, N_IN=12)
//               against a dot-product / argmax reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fc_argmax_bank;

    localparam int N_CLASSES = 10;
    localparam int N_IN      = 12;
    localparam int ACC_W     = $clog2(N_IN + 1) + 1;
    localparam int IDX_W     = $clog2(N_CLASSES);

    logic                    clk    = 1'b0;
    logic                    rstn   = 1'b1;
    logic                    start  = 1'b0;
    logic                    ivalid = 1'b0;
    logic                    din    = 1'b0;
    logic [N_CLASSES-1:0]    weight = '0;
    logic                    in_ready;
    logic                    busy;
    logic                    done;
    logic [IDX_W-1:0]        class_idx;
    logic [N_CLASSES-1:0]    class_onehot;
    logic signed [ACC_W-1:0] max_score;
`ifdef FC_SCORE_OUT_EN
    logic [N_CLASSES*ACC_W-1:0] scores;
`endif

    fc_argmax_bank #(
        .N_CLASSES (N_CLASSES),
        .N_IN      (N_IN)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .start        (start),
        .ivalid       (ivalid),
        .din          (din),
        .weight       (weight),
        .in_ready     (in_ready),
        .busy         (busy),
        .done         (done),
        .class_idx    (class_idx),
        .class_onehot (class_onehot),
        .max_score    (max_score)
`ifdef FC_SCORE_OUT_EN
        ,
        .scores       (scores)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [N_CLASSES-1:0] wq [N_IN];
    bit                   dq [N_IN];
    int                   score [N_CLASSES];
    int                   exp_idx;
    int                   exp_max;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Dot product of +/-1 vectors, then first-maximum search.
    task automatic compute_ref();
        for (int c = 0; c < N_CLASSES; c++) begin
            score[c] = 0;
            for (int i = 0; i < N_IN; i++)
                score[c] += (dq[i] == wq[i][c]) ? 1 : -1;
        end
        exp_idx = 0;
        exp_max = score[0];
        for (int c = 1; c < N_CLASSES; c++)
            if (score[c] > exp_max) begin
                exp_max = score[c];
                exp_idx = c;
            end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_busy"},     busy,         0);
        check({tag, "_in_ready"}, in_ready,     0);
        check({tag, "_done"},     done,         0);
        check({tag, "_idx"},      class_idx,    0);
        check({tag, "_onehot"},   class_onehot, 0);
        check({tag, "_max"},      int'(max_score), 0);
    endtask

    // Runs one frame from wq/dq. Called at a negedge with the DUT idle.
    task automatic run_frame(input string tag, input bit gaps, input bit pokes, input bit beat_with_start);
        int lat;
        compute_ref();
        @(negedge clk);
        start = 1'b1;
        if (beat_with_start) begin
            ivalid = 1'b1;
            din    = 1'($urandom);
            weight = N_CLASSES'($urandom);
        end
        @(negedge clk);
        start  = 1'b0;
        ivalid = 1'b0;
        check({tag, "_busy_accum"}, busy, 1);
        for (int i = 0; i < N_IN; i++) begin
            if (gaps) begin
                while ($urandom_range(1, 0) == 0) begin
                    ivalid = 1'b0;
                    din    = 1'($urandom);
                    weight = N_CLASSES'($urandom);
                    @(negedge clk);
                end
            end
            check({tag, "_in_ready"}, in_ready, 1);
            ivalid = 1'b1;
            din    = dq[i];
            weight = wq[i];
            start  = pokes && (i == 3);
            @(negedge clk);
        end
        ivalid = 1'b0;
        start  = pokes;
        check({tag, "_in_ready_after"}, in_ready, 0);
        lat = 1;
        while (!done && lat < 40) begin
            @(negedge clk);
            start = 1'b0;
            lat++;
        end
        check({tag, "_latency"}, lat, N_CLASSES + 1);
        check({tag, "_busy_done"}, busy, 0);
        check({tag, "_idx"}, class_idx, exp_idx);
        check({tag, "_onehot"}, class_onehot, longint'(1) << exp_idx);
        check({tag, "_max"}, int'(max_score), exp_max);
`ifdef FC_SCORE_OUT_EN
        for (int c = 0; c < N_CLASSES; c++)
            check({tag, "_scores"}, int'($signed(scores[c*ACC_W +: ACC_W])), score[c]);
`endif
        // Start and beats arriving in DONE must be ignored.
        start  = pokes;
        ivalid = pokes;
        @(negedge clk);
        start  = 1'b0;
        ivalid = 1'b0;
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_idle_busy"}, busy, 0);
        check({tag, "_hold_idx"}, class_idx, exp_idx);
        check({tag, "_hold_max"}, int'(max_score), exp_max);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int done_seen;

        repeat (3) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        check_zero_outputs("reset");

        // One class matches every beat, the rest mismatch every beat.
        for (int i = 0; i < N_IN; i++) begin
            dq[i] = 1'b1;
            wq[i] = 10'h008;
        end
        run_frame("single", 1'b0, 1'b0, 1'b0);
        check("single_const_idx", class_idx, 3);
        check("single_const_max", int'(max_score), 12);

        // Alternating input against identical weights: all-zero tie.
        for (int i = 0; i < N_IN; i++) begin
            dq[i] = (i % 2 == 0);
            wq[i] = 10'h3FF;
        end
        run_frame("tie_all", 1'b0, 1'b0, 1'b1);
        check("tie_all_const_onehot", class_onehot, 10'h001);

        // Classes 2 and 7 both +10, class 9 +8, others -12.
        for (int i = 0; i < N_IN; i++) begin
            dq[i] = 1'b1;
            wq[i] = '0;
            if (i < 11) wq[i] = wq[i] | 10'h084;
            if (i < 10) wq[i] = wq[i] | 10'h200;
        end
        run_frame("tie_27", 1'b0, 1'b1, 1'b0);
        check("tie_27_const_idx", class_idx, 2);

        for (int f = 0; f < 15; f++) begin
            for (int i = 0; i < N_IN; i++) begin
                dq[i] = 1'($urandom);
                wq[i] = N_CLASSES'($urandom);
            end
            run_frame("rand", 1'b1, 1'($urandom), 1'($urandom));
        end

        // Reset mid-frame: outputs cleared and no done afterwards.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ivalid = 1'b1;
            din    = 1'($urandom);
            weight = N_CLASSES'($urandom);
            @(negedge clk);
        end
        ivalid = 1'b0;
        rstn   = 1'b1;
        @(negedge clk);
        rstn = 1'b0;
        check_zero_outputs("midreset");
        done_seen = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check("midreset_no_done", done_seen, 0);

        for (int i = 0; i < N_IN; i++) begin
            dq[i] = 1'($urandom);
            wq[i] = N_CLASSES'($urandom);
        end
        run_frame("post_reset", 1'b1, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
